ddr3_rd_unpack: RTL and testbench
=================================

DDR3_RD_UNPACK -- requirements
Module: ddr3_rd_unpack

Interface
REQ-001 SHALL have parameters: DATA_W, default 128, read-FIFO word width; PIX_W, default 16, pixel width; LOAD_PULSE, default 16, rd_load pulse length in cycles; FLUSH_CYC, default 512, FIFO drain window in cycles.
REQ-002 SHALL have port clk, input, 1, display-side clock; the only clock in the block.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port frame_start, input, 1, display frame-start level, synchronous to clk.
REQ-005 SHALL have port pix_req, input, 1, display pixel request, one pixel per asserted cycle.
REQ-006 SHALL have port rfifo_dout, input, DATA_W, read-FIFO output data.
REQ-007 SHALL have port rfifo_empty, input, 1, read-FIFO empty flag.
REQ-008 SHALL have port rfifo_rden, output, 1, read-FIFO read enable; standard FIFO, data valid one cycle after rden.
REQ-009 SHALL have port rd_load, output, 1, frame-restart pulse to the DDR3 read controller.
REQ-010 SHALL have port pix_data, output, PIX_W, unpacked pixel.
REQ-011 SHALL have port pix_valid, output, 1, pix_data valid.
REQ-012 SHALL have port underflow, output, 1, one-cycle pulse: pixel requested with no data available.

Function
REQ-013 SHALL implement states IDLE, FLUSH, FILL and RUN.
REQ-014 IDLE SHALL be the reset state; leave only on a frame_start rising edge, detected as current high and previous-cycle low.
REQ-015 Any frame_start rising edge, in any state, SHALL go to FLUSH, clear both word buffers and the lane counter, cancel the in-flight read, reload the flush counter and restart the rd_load pulse.
REQ-016 rd_load SHALL be high for exactly LOAD_PULSE cycles, starting the cycle after the edge.
REQ-017 In FLUSH: rfifo_rden = !rfifo_empty; returned data discarded; after FLUSH_CYC cycles go to FILL.
REQ-018 Two word registers SHALL exist, cur (being unpacked) and nxt (prefetch), each with a valid bit.
REQ-019 In FILL/RUN, rfifo_rden SHALL assert only when rfifo_empty=0, no read is in flight, and the word will land in a free register; at most one read is outstanding.
REQ-020 Returned word SHALL load cur if cur is empty or being retired that cycle and nxt is empty, else load nxt.
REQ-021 FILL SHALL go to RUN when cur and nxt are both valid.
REQ-022 In RUN, pix_req with cur valid SHALL drive pix_data = lane L of cur one cycle later with pix_valid=1.
REQ-023 Lane 0 SHALL be cur[DATA_W-1 -: PIX_W]; lanes ascend toward LSB.
REQ-024 Lane counter L SHALL run 0..DATA_W/PIX_W-1; on the last lane with pix_req, cur retires and nxt moves to cur in the same cycle, giving a gapless stream.
REQ-025 In RUN, pix_req with cur invalid SHALL give pix_valid=0, pix_data held, underflow=1 next cycle, and L unchanged.
REQ-026 pix_req outside RUN SHALL be ignored: no pix_valid, no underflow.
REQ-027 A frame_start edge in the same cycle as a returning read SHALL discard the data.

Reset
REQ-028 On rst_n low: state=IDLE, rfifo_rden=0, rd_load=0, pix_data=0, pix_valid=0, underflow=0, all valid bits, counters and edge register cleared.
REQ-029 Reset mid-frame SHALL abandon all buffered data; no output is produced until the next frame_start edge.

Configuration
REQ-030 Macro UNDERFLOW_CNT_EN defined: SHALL add output underflow_cnt, 16 bits, counting underflow pulses, saturating at 0xFFFF, cleared on reset and on each frame_start edge.
REQ-031 UNDERFLOW_CNT_EN undefined: underflow_cnt port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-032 Package ddr3_disp_pkg SHALL hold the state encoding (one-hot, 4 bits: IDLE=0001, FLUSH=0010, FILL=0100, RUN=1000) and the DATA_W/PIX_W defaults.
REQ-033 The word-buffer pair with its in-flight tracking SHALL be sub-module unpack_wbuf2; the FSM, lane mux and rd_load generation stay in the top level.

Verification
REQ-034 Reset, then frame_start edge -> rd_load high cycles 1..16; FLUSH reads a FIFO preloaded with 5 stale words; none reach pix_data.
REQ-035 After FLUSH, FIFO holds words 0x0001_0002_..._0008 and 0x0009_..._0010; 16 back-to-back pix_req -> pix_data 0x0001..0x0010 consecutively, pix_valid continuously 1.
REQ-036 FIFO holds one word, 9 pix_req in RUN -> 8 valid pixels, 9th gives pix_valid=0 and underflow=1; with UNDERFLOW_CNT_EN, underflow_cnt=1.
REQ-037 frame_start edge at lane 3 of RUN -> buffers cleared, state FLUSH, next valid pixel is lane 0 of the first post-flush word.
REQ-038 rst_n low for one cycle during RUN with a read in flight -> all outputs 0 at once; no pix_valid until a new frame_start edge.
REQ-039 Toggling rfifo_empty randomly during RUN -> rfifo_rden never asserts while empty, never more than one read outstanding, no pixel lost or duplicated.

Source files
------------

// File: rtl/ddr3_disp_pkg.sv
// rtl/ddr3_disp_pkg.sv - shared state encoding and width defaults for the DDR3 display read path
package ddr3_disp_pkg;

    localparam int DEF_DATA_W = 128;
    localparam int DEF_PIX_W  = 16;

    // One-hot so each state decode is a single flop bit
    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_FLUSH = 4'b0010,
        ST_FILL  = 4'b0100,
        ST_RUN   = 4'b1000
    } disp_state_e;

endpackage

// File: rtl/unpack_wbuf2.sv
// rtl/unpack_wbuf2.sv - two-deep word buffer (cur + prefetch) with single outstanding FIFO read
module unpack_wbuf2
    import ddr3_disp_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              fetch_en_i,
    input  logic              fifo_empty_i,
    input  logic [DATA_W-1:0] fifo_dout_i,
    input  logic              retire_i,
    output logic              rd_req_o,
    output logic [DATA_W-1:0] cur_o,
    output logic              cur_v_o,
    output logic              nxt_v_o
);

    logic [DATA_W-1:0] cur_q, cur_d;
    logic [DATA_W-1:0] nxt_q, nxt_d;
    logic              cur_v_q, cur_v_d;
    logic              nxt_v_q, nxt_v_d;
    logic              infl_q, infl_d;

    always_comb begin
        cur_d   = cur_q;
        nxt_d   = nxt_q;
        cur_v_d = cur_v_q;
        nxt_v_d = nxt_v_q;
        if (retire_i) begin
            cur_d   = nxt_q;
            cur_v_d = nxt_v_q;
            nxt_v_d = 1'b0;
        end
        // Read latency is one cycle, so a read issued last cycle lands now
        if (infl_q) begin
            if (!cur_v_d) begin
                cur_d   = fifo_dout_i;
                cur_v_d = 1'b1;
            end else begin
                nxt_d   = fifo_dout_i;
                nxt_v_d = 1'b1;
            end
        end
        rd_req_o = fetch_en_i && !fifo_empty_i && !infl_q && !(cur_v_d && nxt_v_d);
        infl_d   = rd_req_o;
        if (clr_i) begin
            cur_v_d  = 1'b0;
            nxt_v_d  = 1'b0;
            infl_d   = 1'b0;
            rd_req_o = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q   <= '0;
            nxt_q   <= '0;
            cur_v_q <= 1'b0;
            nxt_v_q <= 1'b0;
            infl_q  <= 1'b0;
        end else begin
            cur_q   <= cur_d;
            nxt_q   <= nxt_d;
            cur_v_q <= cur_v_d;
            nxt_v_q <= nxt_v_d;
            infl_q  <= infl_d;
        end
    end

    assign cur_o   = cur_q;
    assign cur_v_o = cur_v_q;
    assign nxt_v_o = nxt_v_q;

endmodule

// File: rtl/ddr3_rd_unpack.sv
// rtl/ddr3_rd_unpack.sv - frame-synchronous read-FIFO word unpacker to pixels; UNDERFLOW_CNT_EN adds underflow_cnt
module ddr3_rd_unpack
    import ddr3_disp_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int PIX_W      = DEF_PIX_W,
    parameter int LOAD_PULSE = 16,
    parameter int FLUSH_CYC  = 512
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              pix_req,
    input  logic [DATA_W-1:0] rfifo_dout,
    input  logic              rfifo_empty,
    output logic              rfifo_rden,
    output logic              rd_load,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_valid,
    output logic              underflow
`ifdef UNDERFLOW_CNT_EN
    ,
    output logic [15:0]       underflow_cnt
`endif
);

    localparam int LANES  = DATA_W / PIX_W;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int FL_W   = $clog2(FLUSH_CYC + 1);
    localparam int LD_W   = $clog2(LOAD_PULSE + 1);

    disp_state_e       state_q, state_d;
    logic              fs_q;
    logic              fs_edge;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [FL_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic [LD_W-1:0]   ld_cnt_q, ld_cnt_d;
    logic              rd_load_q, rd_load_d;
    logic [PIX_W-1:0]  pix_data_q, pix_data_d;
    logic              pix_valid_q, pix_valid_d;
    logic              underflow_q, underflow_d;

    logic [DATA_W-1:0] cur_word;
    logic [DATA_W-1:0] pix_shift;
    logic [PIX_W-1:0]  pix_sel;
    logic              cur_v, nxt_v;
    logic              wb_rd_req;
    logic              lane_last;
    logic              retire;
    logic              fetch_en;

    assign fs_edge   = frame_start && !fs_q;
    assign lane_last = (lane_q == LANE_W'(LANES - 1));
    assign retire    = (state_q == ST_RUN) && pix_req && !fs_edge && cur_v && lane_last;
    assign fetch_en  = ((state_q == ST_FILL) || (state_q == ST_RUN)) && !fs_edge;

    // Flush reads are not tracked by the buffer, so their data is dropped
    assign rfifo_rden = (state_q == ST_FLUSH) ? !rfifo_empty : wb_rd_req;

    // Lane 0 sits in the MSBs of the word
    assign pix_shift = cur_word << (lane_q * PIX_W);
    assign pix_sel   = pix_shift[DATA_W-1 -: PIX_W];

    unpack_wbuf2 #(
        .DATA_W (DATA_W)
    ) u_wbuf (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_i        (fs_edge),
        .fetch_en_i   (fetch_en),
        .fifo_empty_i (rfifo_empty),
        .fifo_dout_i  (rfifo_dout),
        .retire_i     (retire),
        .rd_req_o     (wb_rd_req),
        .cur_o        (cur_word),
        .cur_v_o      (cur_v),
        .nxt_v_o      (nxt_v)
    );

    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        flush_cnt_d = flush_cnt_q;
        ld_cnt_d    = ld_cnt_q;
        rd_load_d   = (ld_cnt_q != '0);
        pix_data_d  = pix_data_q;
        pix_valid_d = 1'b0;
        underflow_d = 1'b0;
        if (ld_cnt_q != '0) begin
            ld_cnt_d = ld_cnt_q - 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_FLUSH: begin
                if (flush_cnt_q == '0) begin
                    state_d = ST_FILL;
                end else begin
                    flush_cnt_d = flush_cnt_q - 1'b1;
                end
            end
            ST_FILL: begin
                if (cur_v && nxt_v) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (pix_req) begin
                    if (cur_v) begin
                        pix_data_d  = pix_sel;
                        pix_valid_d = 1'b1;
                        lane_d      = lane_last ? '0 : lane_q + 1'b1;
                    end else begin
                        underflow_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // A new frame overrides whatever the current state was doing
        if (fs_edge) begin
            state_d     = ST_FLUSH;
            lane_d      = '0;
            flush_cnt_d = FL_W'(FLUSH_CYC - 1);
            ld_cnt_d    = LD_W'(LOAD_PULSE - 1);
            rd_load_d   = 1'b1;
            pix_valid_d = 1'b0;
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            fs_q        <= 1'b0;
            lane_q      <= '0;
            flush_cnt_q <= '0;
            ld_cnt_q    <= '0;
            rd_load_q   <= 1'b0;
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fs_q        <= frame_start;
            lane_q      <= lane_d;
            flush_cnt_q <= flush_cnt_d;
            ld_cnt_q    <= ld_cnt_d;
            rd_load_q   <= rd_load_d;
            pix_data_q  <= pix_data_d;
            pix_valid_q <= pix_valid_d;
            underflow_q <= underflow_d;
        end
    end

    assign rd_load   = rd_load_q;
    assign pix_data  = pix_data_q;
    assign pix_valid = pix_valid_q;
    assign underflow = underflow_q;

`ifdef UNDERFLOW_CNT_EN
    logic [15:0] uf_cnt_q, uf_cnt_d;

    // Counts alongside the pulse so the count is visible in the same cycle
    always_comb begin
        uf_cnt_d = uf_cnt_q;
        if (fs_edge) begin
            uf_cnt_d = '0;
        end else if (underflow_d && (uf_cnt_q != 16'hFFFF)) begin
            uf_cnt_d = uf_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uf_cnt_q <= '0;
        end else begin
            uf_cnt_q <= uf_cnt_d;
        end
    end

    assign underflow_cnt = uf_cnt_q;
`endif

endmodule

// File: tb/tb_ddr3_rd_unpack.sv
// tb/tb_ddr3_rd_unpack.sv - directed self-checking bench for ddr3_rd_unpack
module tb_ddr3_rd_unpack;

    logic         clk;
    logic         rst_n;
    logic         frame_start;
    logic         pix_req;
    logic [127:0] rfifo_dout;
    logic         rfifo_empty;
    logic         rfifo_rden;
    logic         rd_load;
    logic [15:0]  pix_data;
    logic         pix_valid;
    logic         underflow;
`ifdef UNDERFLOW_CNT_EN
    logic [15:0]  underflow_cnt;
`endif

    ddr3_rd_unpack dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .pix_req     (pix_req),
        .rfifo_dout  (rfifo_dout),
        .rfifo_empty (rfifo_empty),
        .rfifo_rden  (rfifo_rden),
        .rd_load     (rd_load),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .underflow   (underflow)
`ifdef UNDERFLOW_CNT_EN
        ,
        .underflow_cnt (underflow_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [127:0] fifo_q[$];
    logic [15:0]  pix_log[$];
    logic         hold_empty;
    logic         chk_outst;
    logic         prev_rden;
    logic         last_rd_load;
    logic         rd_now;
    int           uf_seen;
    int           rd_load_hi;
    int           viol_empty;
    int           viol_outst;
    int           n_chk;
    int           n_err;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] mk_word(input logic [15:0] base);
        logic [127:0] w;
        w = '0;
        for (int j = 0; j < 8; j++) begin
            w[127 - 16*j -: 16] = base + 16'(j);
        end
        return w;
    endfunction

    // One clock: inputs are already applied at posedge+1; outputs sampled on the negedge
    task automatic step();
        rfifo_empty = (fifo_q.size() == 0) || hold_empty;
        @(negedge clk);
        if (pix_valid) pix_log.push_back(pix_data);
        if (underflow) uf_seen++;
        last_rd_load = rd_load;
        if (rd_load) rd_load_hi++;
        rd_now = rfifo_rden;
        if (rd_now && rfifo_empty) viol_empty++;
        if (chk_outst && rd_now && prev_rden) viol_outst++;
        prev_rden = rd_now;
        @(posedge clk);
        #1;
        if (rd_now && fifo_q.size() > 0) rfifo_dout = fifo_q.pop_front();
        rfifo_empty = (fifo_q.size() == 0) || hold_empty;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int first_ld;
        int found;
        int seq_err;
        n_chk = 0; n_err = 0;
        uf_seen = 0; rd_load_hi = 0; viol_empty = 0; viol_outst = 0;
        chk_outst = 1'b0; prev_rden = 1'b0; last_rd_load = 1'b0; rd_now = 1'b0;
        rst_n = 1'b0; frame_start = 1'b0; pix_req = 1'b0;
        rfifo_dout = '0; hold_empty = 1'b0; rfifo_empty = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_rden", rfifo_rden, 0);
        check("rst_rd_load", rd_load, 0);
        check("rst_pix_data", pix_data, 0);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_underflow", underflow, 0);
        rst_n = 1'b1;

        // IDLE ignores requests; stale words wait in the FIFO
        pix_req = 1'b1;
        for (int k = 0; k < 5; k++) fifo_q.push_back(mk_word(16'hE000 + 16'(k * 8)));
        steps(4);

        frame_start = 1'b1;
        first_ld = -1;
        rd_load_hi = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (last_rd_load && first_ld < 0) first_ld = i;
        end
        check("rd_load_first", first_ld, 1);
        check("rd_load_len", rd_load_hi, 16);
        frame_start = 1'b0;
        steps(500);
        pix_req = 1'b0;
        steps(10);
        check("flush_drained", fifo_q.size(), 0);
        check("idle_flush_nopix", pix_log.size(), 0);
        check("idle_flush_nouf", uf_seen, 0);

        // Two words streamed gaplessly
        fifo_q.push_back(mk_word(16'h0001));
        fifo_q.push_back(mk_word(16'h0009));
        steps(8);
        pix_req = 1'b1;
        steps(16);
        pix_req = 1'b0;
        step();
        check("stream_cnt", pix_log.size(), 16);
        for (int i = 0; i < 16 && i < pix_log.size(); i++)
            check($sformatf("stream_pix%0d", i), pix_log[i], 16'h0001 + 16'(i));
        check("stream_nouf", uf_seen, 0);

        // One word, nine requests
        pix_log.delete();
        uf_seen = 0;
        fifo_q.push_back(mk_word(16'h0011));
        steps(6);
        pix_req = 1'b1;
        steps(9);
        pix_req = 1'b0;
        steps(2);
        check("uf_valid_cnt", pix_log.size(), 8);
        if (pix_log.size() == 8) check("uf_last_pix", pix_log[7], 16'h0018);
        check("uf_pulses", uf_seen, 1);
        check("uf_data_held", pix_data, 16'h0018);
`ifdef UNDERFLOW_CNT_EN
        check("uf_cnt", underflow_cnt, 1);
`endif

        // Frame restart at lane 3
        pix_log.delete();
        uf_seen = 0;
        fifo_q.push_back(mk_word(16'h0021));
        fifo_q.push_back(mk_word(16'h0029));
        steps(6);
        pix_req = 1'b1;
        steps(3);
        pix_req = 1'b0;
        step();
        check("pre_edge_cnt", pix_log.size(), 3);
        if (pix_log.size() == 3) check("pre_edge_lane2", pix_log[2], 16'h0023);
        frame_start = 1'b1;
        step();
        check("edge_state_flush", dut.state_q, 4'b0010);
        check("edge_cur_cleared", dut.u_wbuf.cur_v_q, 0);
        check("edge_nxt_cleared", dut.u_wbuf.nxt_v_q, 0);
        frame_start = 1'b0;
        steps(530);
        pix_log.delete();
        fifo_q.push_back(mk_word(16'h0041));
        fifo_q.push_back(mk_word(16'h0049));
        steps(8);
        pix_req = 1'b1;
        step();
        pix_req = 1'b0;
        step();
        check("restart_cnt", pix_log.size(), 1);
        if (pix_log.size() >= 1) check("restart_lane0", pix_log[0], 16'h0041);

        // Reset while a read is in flight
        fifo_q.push_back(mk_word(16'h0051));
        pix_req = 1'b1;
        found = 0;
        for (int i = 0; i < 30; i++) begin
            rfifo_empty = (fifo_q.size() == 0) || hold_empty;
            @(negedge clk);
            if (rfifo_rden) begin
                found = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("inflight_found", found, 1);
        @(posedge clk);
        #1;
        if (found == 1 && fifo_q.size() > 0) rfifo_dout = fifo_q.pop_front();
        rst_n = 1'b0;
        #1;
        check("arst_pix_valid", pix_valid, 0);
        check("arst_pix_data", pix_data, 0);
        check("arst_underflow", underflow, 0);
        check("arst_rd_load", rd_load, 0);
        check("arst_rden", rfifo_rden, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        fifo_q.push_back(mk_word(16'h0059));
        pix_log.delete();
        uf_seen = 0;
        rd_load_hi = 0;
        steps(30);
        check("post_rst_nopix", pix_log.size(), 0);
        check("post_rst_nouf", uf_seen, 0);
        check("post_rst_noload", rd_load_hi, 0);
        check("post_rst_idle", dut.state_q, 4'b0001);

        // Random empty toggling during RUN
        pix_req = 1'b0;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        steps(530);
        pix_log.delete();
        uf_seen = 0;
        prev_rden = 1'b0;
        chk_outst = 1'b1;
        for (int k = 0; k < 6; k++) fifo_q.push_back(mk_word(16'h0061 + 16'(k * 8)));
        for (int i = 0; i < 1500 && pix_log.size() < 48; i++) begin
            pix_req = 1'($urandom_range(0, 1));
            hold_empty = 1'($urandom_range(0, 1));
            step();
        end
        pix_req = 1'b0;
        hold_empty = 1'b0;
        steps(2);
        chk_outst = 1'b0;
        seq_err = 0;
        for (int i = 0; i < pix_log.size(); i++)
            if (pix_log[i] !== 16'h0061 + 16'(i)) seq_err++;
        check("rand_pix_cnt", pix_log.size(), 48);
        check("rand_seq_err", seq_err, 0);
        check("rden_while_empty", viol_empty, 0);
        check("multi_outstanding", viol_outst, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
